// File: rtl/less_than_32.sv
// Registered set-on-less-than unit: out[0] = (a < b), signed or unsigned,
// decided by an MSB-first bit comparator chain, one cycle of latency.
module less_than_32 #(
  parameter int WIDTH      = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic decided;
  logic lt_d;
  logic lt_q;
  logic out_valid_q;

  // The first differing bit from the MSB decides. In signed mode a differing
  // sign bit means a is the negative one exactly when a[MSB] is set.
  always_comb begin
    decided = 1'b0;
    lt_d    = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!decided && (a[i] != b[i])) begin
        decided = 1'b1;
        if ((i == WIDTH - 1) && SIGNED_CMP)
          lt_d = a[i];
        else
          lt_d = b[i];
      end
    end
  end

  // Only the result bit is stored; the upper bits are tied to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid)
        lt_q <= lt_d;
    end
  end

  assign out       = {{(WIDTH-1){1'b0}}, lt_q};
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_less_than_32.sv
// Self-checking bench for less_than_32: signed and unsigned instances side by
// side, table vectors, hand-written handshake/reset sequences, random stimulus.
module tb_less_than_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out_s;
  logic [31:0] out_u;
  logic        out_valid_s;
  logic        out_valid_u;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_s;
  logic [31:0] exp_u;
  logic        exp_v;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        lt_s;
    logic        lt_u;
  } vec_t;

  vec_t vecs [9];

  less_than_32 #(.WIDTH(32), .SIGNED_CMP(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out(out_s), .out_valid(out_valid_s)
  );

  less_than_32 #(.WIDTH(32), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out(out_u), .out_valid(out_valid_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string tag);
    check32({tag, " out signed"},   out_s, exp_s);
    check32({tag, " out unsigned"}, out_u, exp_u);
    check32({tag, " valid signed"},   {31'b0, out_valid_s}, {31'b0, exp_v});
    check32({tag, " valid unsigned"}, {31'b0, out_valid_u}, {31'b0, exp_v});
  endtask

  // One cycle: check what the previous cycle should have produced, then drive
  // new operands and update the reference expectation from plain arithmetic.
  task automatic step(input string tag, input logic v, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    check_outputs(tag);
    in_valid = v;
    a        = av;
    b        = bv;
    if (v) begin
      exp_s = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      exp_u = (av < bv) ? 32'd1 : 32'd0;
    end
    exp_v = v;
  endtask

  function automatic logic [31:0] pick_edge(input int unsigned k);
    case (k % 8)
      0: pick_edge = 32'h0000_0000;
      1: pick_edge = 32'h0000_0001;
      2: pick_edge = 32'h7FFF_FFFF;
      3: pick_edge = 32'h8000_0000;
      4: pick_edge = 32'h8000_0001;
      5: pick_edge = 32'hFFFF_FFFF;
      6: pick_edge = 32'hFFFF_FFFE;
      default: pick_edge = 32'h4000_0000;
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rv;

    vecs[0] = '{32'h4222_0225, 32'h4002_028A, 1'b0, 1'b0};
    vecs[1] = '{32'h4002_028A, 32'h4222_0225, 1'b1, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1};
    vecs[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    exp_s    = '0;
    exp_u    = '0;
    exp_v    = 1'b0;

    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors issued back to back; each result is checked one cycle later.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check32("tbl signed",   out_s, {31'b0, vecs[i-1].lt_s});
        check32("tbl unsigned", out_u, {31'b0, vecs[i-1].lt_u});
        check32("tbl valid",    {31'b0, out_valid_s}, 32'd1);
      end
      in_valid = 1'b1;
      a        = vecs[i].a;
      b        = vecs[i].b;
    end
    @(negedge clk);
    check32("tbl signed last",   out_s, {31'b0, vecs[8].lt_s});
    check32("tbl unsigned last", out_u, {31'b0, vecs[8].lt_u});
    in_valid = 1'b0;
    exp_s    = {31'b0, vecs[8].lt_s};
    exp_u    = {31'b0, vecs[8].lt_u};
    exp_v    = 1'b0;

    // Result of 1, then idle cycles: valid drops, out holds.
    step("pre-hold", 1'b1, 32'h4002_028A, 32'h4222_0225);
    step("hold0", 1'b0, 32'h4222_0225, 32'h4002_028A);
    step("hold1", 1'b0, 32'h4222_0225, 32'h4002_028A);
    @(negedge clk);
    check_outputs("hold2");

    // Asynchronous reset mid-cycle clears outputs before any clock edge.
    rst_n = 1'b0;
    #1;
    exp_s = '0;
    exp_u = '0;
    exp_v = 1'b0;
    check_outputs("async rst");
    #2;
    check_outputs("async rst held");
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = ra; end
        2: begin ra = $urandom; rb = ra ^ (32'd1 << $urandom_range(0, 31)); end
        default: begin ra = pick_edge($urandom); rb = pick_edge($urandom); end
      endcase
      step("rand", rv, ra, rb);
    end
    @(negedge clk);
    check_outputs("rand final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
